acc_mul_div_seq: RTL

//  Accumulator + multi-cycle multiply/divide sequencer directly downstream of the ALU. Holds 2*WIDTH-bit acc {high,low}.

---
 rtl/acc_mul_div_seq_pkg.sv | 51 +++++
 rtl/acc_mul_div_seq_acc_shift_reg.sv | 54 +++++
 rtl/acc_mul_div_seq.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/acc_mul_div_seq_pkg.sv
// Shared types for the accumulator / multiply-divide sequencer: FSM states,
// decoded idle commands and accumulator register operations.
package acc_mul_div_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV_SHL,
    ST_DIV_SUB,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_MUL,
    CMD_DIV,
    CMD_CLR,
    CMD_LD_HIGH,
    CMD_LD_LOW,
    CMD_SHR,
    CMD_SHL
  } cmd_e;

  typedef enum logic [2:0] {
    ACC_NOP,
    ACC_CLR,
    ACC_LD_HIGH,
    ACC_LD_LOW,
    ACC_SHR,
    ACC_SHL,
    ACC_SET_LSB
  } acc_op_e;

  // Fixed priority: start_mul > start_div > clr > ld_high > ld_low > shr > shl.
  function automatic cmd_e decode_cmd(input logic i_mul, input logic i_div,
                                      input logic i_clr, input logic i_ldh,
                                      input logic i_ldl, input logic i_shr,
                                      input logic i_shl);
    cmd_e w_cmd;
    if (i_mul)      w_cmd = CMD_MUL;
    else if (i_div) w_cmd = CMD_DIV;
    else if (i_clr) w_cmd = CMD_CLR;
    else if (i_ldh) w_cmd = CMD_LD_HIGH;
    else if (i_ldl) w_cmd = CMD_LD_LOW;
    else if (i_shr) w_cmd = CMD_SHR;
    else if (i_shl) w_cmd = CMD_SHL;
    else            w_cmd = CMD_NONE;
    return w_cmd;
  endfunction

endpackage

// File: rtl/acc_mul_div_seq_acc_shift_reg.sv
// 2*WIDTH-bit accumulator {high,low} with clear, loads, shifts and low-bit set.
module acc_shift_reg
  import acc_mul_div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  acc_op_e          i_op,
  input  logic [WIDTH-1:0] i_high,
  input  logic [WIDTH-1:0] i_low,
  input  logic             i_cin,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_high,
  output logic [WIDTH-1:0] o_low
);

  logic [WIDTH-1:0] r_high;
  logic [WIDTH-1:0] r_low;

  // SHR shifts {i_cin, i_high, low}, so a MUL step can load and shift at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_high <= '0;
      r_low  <= '0;
    end else begin
      unique case (i_op)
        ACC_CLR: begin
          r_high <= '0;
          r_low  <= '0;
        end
        ACC_LD_HIGH: r_high <= i_high;
        ACC_LD_LOW:  r_low  <= i_low;
        ACC_SHR: begin
          r_high <= {i_cin, i_high[WIDTH-1:1]};
          r_low  <= {i_high[0], r_low[WIDTH-1:1]};
        end
        ACC_SHL: begin
          r_high <= {r_high[WIDTH-2:0], r_low[WIDTH-1]};
          r_low  <= {r_low[WIDTH-2:0], 1'b0};
        end
        ACC_SET_LSB: begin
          r_high   <= i_high;
          r_low[0] <= i_bit;
        end
        default: ;
      endcase
    end
  end

  assign o_high = r_high;
  assign o_low  = r_low;

endmodule

// File: rtl/acc_mul_div_seq.sv
// Accumulator plus shift-add MUL / restoring DIV sequencer driving the ALU strobes.
module acc_mul_div_seq
  import acc_mul_div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] bus_data,
  input  logic [WIDTH-1:0] alu_data,
  input  logic             alu_cout,
  input  logic             acc_clr,
  input  logic             acc_ld_high,
  input  logic             acc_ld_low,
  input  logic             acc_shr,
  input  logic             acc_shl,
  input  logic             start_mul,
  input  logic             start_div,
  output logic [WIDTH-1:0] acc_high_data,
  output logic [WIDTH-1:0] acc_low_data,
  output logic             acc_lsb,
  output logic             op_mul,
  output logic             op_div,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_div_zero;
  cmd_e             w_cmd;
  logic             w_last;
  logic             w_bus_zero;
  acc_op_e          w_op;
  logic [WIDTH-1:0] w_d_high;
  logic             w_cin;
  logic             w_bit;

  assign w_cmd      = decode_cmd(start_mul, start_div, acc_clr, acc_ld_high,
                                 acc_ld_low, acc_shr, acc_shl);
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_bus_zero = (bus_data == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_cmd == CMD_MUL)      w_next = ST_MUL;
        else if (w_cmd == CMD_DIV) w_next = w_bus_zero ? ST_DONE : ST_DIV_SHL;
      end
      ST_MUL:     if (w_last) w_next = ST_DONE;
      ST_DIV_SHL: w_next = ST_DIV_SUB;
      ST_DIV_SUB: w_next = w_last ? ST_DONE : ST_DIV_SHL;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Step counter advances once per MUL step and once per SHL/SUB pair.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (r_state == ST_MUL || r_state == ST_DIV_SUB) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_zero <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (w_cmd == CMD_MUL)      r_div_zero <= 1'b0;
      else if (w_cmd == CMD_DIV) r_div_zero <= w_bus_zero;
    end
  end

  always_comb begin
    busy     = (r_state != ST_IDLE);
    done     = (r_state == ST_DONE);
    op_mul   = (r_state == ST_MUL);
    op_div   = (r_state == ST_DIV_SUB);
    w_op     = ACC_NOP;
    w_d_high = acc_high_data;
    w_cin    = 1'b0;
    w_bit    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        unique case (w_cmd)
          CMD_MUL: begin
            w_op     = ACC_LD_HIGH;
            w_d_high = '0;
          end
          CMD_DIV: begin
            w_op     = w_bus_zero ? ACC_NOP : ACC_LD_HIGH;
            w_d_high = '0;
          end
          CMD_CLR:     w_op = ACC_CLR;
          CMD_LD_HIGH: begin
            w_op     = ACC_LD_HIGH;
            w_d_high = alu_data;
          end
          CMD_LD_LOW:  w_op = ACC_LD_LOW;
          CMD_SHR:     w_op = ACC_SHR;
          CMD_SHL:     w_op = ACC_SHL;
          default:     w_op = ACC_NOP;
        endcase
      end
      ST_MUL: begin
        w_op     = ACC_SHR;
        w_d_high = acc_lsb ? alu_data : acc_high_data;
        w_cin    = acc_lsb & alu_cout;
      end
      ST_DIV_SHL: w_op = ACC_SHL;
      ST_DIV_SUB: begin
        w_op     = ACC_SET_LSB;
        w_d_high = alu_cout ? alu_data : acc_high_data;
        w_bit    = alu_cout;
      end
      default: w_op = ACC_NOP;
    endcase
  end

  acc_shift_reg #(.WIDTH(WIDTH)) u_acc (
    .clk    (clk),
    .rst_n  (reset_n),
    .i_op   (w_op),
    .i_high (w_d_high),
    .i_low  (bus_data),
    .i_cin  (w_cin),
    .i_bit  (w_bit),
    .o_high (acc_high_data),
    .o_low  (acc_low_data)
  );

  assign acc_lsb  = acc_low_data[0];
  assign div_zero = r_div_zero;

endmodule
